// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
// Optional feature macro: IFETCH_PREDECODE_EN (per-entry branch/jump flags).
package ifetch_pkg;

  // Primary opcode field values (inst[31:26]) recognised by predecode.
  localparam logic [5:0] OP_J   = 6'h02;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_BNE = 6'h05;

  // Memory request FSM: IDLE = no request on the bus, REQ = imem_req held.
  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } req_state_t;

`ifdef IFETCH_PREDECODE_EN
  typedef struct packed {
    logic is_branch;
    logic is_jump;
  } ifq_flags_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    ifq_flags_t  flags;
  } ifq_entry_t;

  function automatic ifq_flags_t predecode(input logic [31:0] inst);
    ifq_flags_t f;
    f.is_branch = (inst[31:26] == OP_BEQ) || (inst[31:26] == OP_BNE);
    f.is_jump   = (inst[31:26] == OP_J)   || (inst[31:26] == OP_JAL);
    return f;
  endfunction
`else
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ifq_entry_t;
`endif

endpackage

// File: rtl/ifq_fifo.sv
// Synchronous FIFO with combinational head, occupancy count and flush.
// Push and pop may coincide at any occupancy, including full.
module ifq_fifo #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             is_empty;
  logic             is_full;
  logic             do_push;
  logic             do_pop;

  assign is_empty = (count == '0);
  assign is_full  = (count == CW'(DEPTH));
  assign do_pop   = pop && !is_empty;
  // When full, a push is only taken if the head is leaving the same cycle.
  assign do_push  = push && (!is_full || do_pop);
  assign head     = mem[rd_ptr];

  // Pointer, count and storage update; flush discards contents.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch queue: accepts PCs, issues in-order memory reads,
// tags returns with their PC and buffers them for decode. A redirect
// flushes everything and discards returns still in flight.
// Optional feature macro: IFETCH_PREDECODE_EN adds inst_is_branch/inst_is_jump.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned MAX_OUT = 2
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] pc_in,
  input  logic        pc_valid,
  output logic        pc_ready,
  input  logic        redirect,
  output logic        imem_req,
  input  logic        imem_gnt,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc
`ifdef IFETCH_PREDECODE_EN
  ,
  output logic        inst_is_branch,
  output logic        inst_is_jump
`endif
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned SW = CW + 1;

  req_state_t  state;
  logic        req_stale;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] outstanding_next;
  logic [CW-1:0] drop_count;
  logic [CW-1:0] q_count;
  logic [CW-1:0] t_count;
  logic [SW-1:0] credit_used;

  logic        pending;
  logic        gnt_fire;
  logic        pc_fire;
  logic        ret_fire;
  logic        ret_keep;
  logic        ret_drop;
  logic        tag_push;
  logic [31:0] tag_head;
  logic [31:0] aligned_pc;
  ifq_entry_t  q_wdata;
  ifq_entry_t  q_head;
  logic        q_pop;
  logic        unused_pc_lsb;

  assign unused_pc_lsb = ^pc_in[1:0];
  assign aligned_pc    = {pc_in[31:2], 2'b00};

  assign pending     = (state == REQ);
  assign gnt_fire    = pending && imem_gnt;
  assign credit_used = SW'(q_count) + SW'(outstanding) + SW'(pending);
  assign pc_ready    = !redirect
                    && ((state == IDLE) || imem_gnt)
                    && (credit_used < SW'(DEPTH))
                    && (outstanding < CW'(MAX_OUT));
  assign pc_fire     = pc_valid && pc_ready;

  // Returns with nothing outstanding are spurious and ignored; a return in a
  // redirect cycle or while drop_count is non-zero belongs to the old stream.
  assign ret_fire = imem_rvalid && (outstanding != '0);
  assign ret_drop = ret_fire && !redirect && (drop_count != '0);
  assign ret_keep = ret_fire && !redirect && (drop_count == '0) && (t_count != '0);

  // A stale request (caught in REQ by a redirect) is already in drop_count,
  // so its grant must not create a tag.
  assign tag_push = gnt_fire && !req_stale && !redirect;
  assign q_pop    = inst_valid && inst_ready;

  assign outstanding_next = outstanding + CW'(gnt_fire) - CW'(ret_fire);

  // Assemble the queue entry from the returning data and its tag.
  always_comb begin
    q_wdata      = '0;
    q_wdata.pc   = tag_head;
    q_wdata.inst = imem_rdata;
`ifdef IFETCH_PREDECODE_EN
    q_wdata.flags = predecode(imem_rdata);
`endif
  end

  // Request FSM: holds imem_req/imem_addr until granted, chaining on grant.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= '0;
      req_stale <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pc_fire) begin
            state     <= REQ;
            imem_req  <= 1'b1;
            imem_addr <= aligned_pc;
            req_stale <= 1'b0;
          end
        end
        REQ: begin
          if (imem_gnt) begin
            req_stale <= 1'b0;
            if (pc_fire) begin
              imem_addr <= aligned_pc;
            end else begin
              state    <= IDLE;
              imem_req <= 1'b0;
            end
          end else if (redirect) begin
            req_stale <= 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

  // In-flight accounting. On redirect every request still owed a return,
  // including one waiting for grant, is marked for discard.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      outstanding <= '0;
      drop_count  <= '0;
    end else begin
      outstanding <= outstanding_next;
      if (redirect) begin
        drop_count <= outstanding_next + CW'(pending && !imem_gnt);
      end else if (ret_drop) begin
        drop_count <= drop_count - 1'b1;
      end
    end
  end

  ifq_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_tag_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (redirect),
    .push      (tag_push),
    .push_data (imem_addr),
    .pop       (ret_keep),
    .head      (tag_head),
    .count     (t_count)
  );

  ifq_fifo #(
    .WIDTH ($bits(ifq_entry_t)),
    .DEPTH (DEPTH)
  ) u_inst_fifo (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (redirect),
    .push      (ret_keep),
    .push_data (q_wdata),
    .pop       (q_pop),
    .head      (q_head),
    .count     (q_count)
  );

  assign inst_valid = (q_count != '0);
  assign inst_out   = q_head.inst;
  assign inst_pc    = q_head.pc;
`ifdef IFETCH_PREDECODE_EN
  assign inst_is_branch = q_head.flags.is_branch;
  assign inst_is_jump   = q_head.flags.is_jump;
`endif

endmodule
